// File: rtl/pipe_pkg.sv
// Shared types and NOP bundle constants for the MIPS pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int unsigned INSTR_W = 32;

  // All-zero word is the MIPS NOP (sll $0,$0,0); used as the bubble payload.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Per-boundary bubble bundles: every control bit deasserted.
  localparam logic [INSTR_W-1:0] IF_ID_NOP  = NOP_INSTR;
  localparam logic [INSTR_W-1:0] ID_EX_NOP  = '0;
  localparam logic [INSTR_W-1:0] EX_MEM_NOP = '0;
  localparam logic [INSTR_W-1:0] MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master: the surrounding stages (upstream producer + downstream consumer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // slave: the stage register itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/en_register.sv
// Load-enabled register with a synchronous two-way load-value select and async reset.
module en_register #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] alt_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= sel_i ? alt_i : d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Skid-buffered pipeline stage register: valid/ready handshake, two entries,
// synchronous flush to a bubble and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt,
  pipe_stage_reg_if.slave  bus
);

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, pop;
  logic             main_en, main_from_skid, skid_en;
  logic [WIDTH-1:0] main_q, skid_q, main_src;

  // Next state, storage enables and stall counter update
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    cnt_d          = cnt_q;
    accept         = bus.in_valid & in_ready_q;
    pop            = out_valid_q & bus.out_ready;

    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b1;
      skid_en = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_en = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            skid_en = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (stall_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && !bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Handshake flags are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      cnt_q       <= cnt_d;
    end
  end

  assign main_src = main_from_skid ? skid_q : bus.in_data;

  en_register #(
    .WIDTH   (WIDTH),
    .RST_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (main_en),
    .sel_i (flush),
    .d_i   (main_src),
    .alt_i (FLUSH_VAL),
    .q_o   (main_q)
  );

  en_register #(
    .WIDTH   (WIDTH),
    .RST_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (skid_en),
    .sel_i (flush),
    .d_i   (bus.in_data),
    .alt_i (FLUSH_VAL),
    .q_o   (skid_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg against a queue-based model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned      WIDTH = 32;
  localparam int unsigned      CNT_W = 2;
  localparam logic [WIDTH-1:0] RVAL  = 32'hDEAD_BEEF;
  localparam logic [WIDTH-1:0] FVAL  = IF_ID_NOP;
  localparam int               CMAX  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             stall_clr;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_stage_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RVAL),
    .FLUSH_VAL (FVAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of held entries, last visible payload, stall count
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] mmain;
  int               mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mmain = RVAL;
    mcnt  = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(mq.size() < 2));
    check({tag, ".out_data"},  bus.out_data,       mmain);
    check({tag, ".stall_cnt"}, 32'(stall_cnt),     32'(mcnt));
  endtask

  // Advance one clock: update model from the pre-edge view, then compare
  task automatic step(input string tag);
    bit acc, pop;
    acc = bus.in_valid && (mq.size() < 2);
    pop = bus.out_ready && (mq.size() > 0);
    if (stall_clr) mcnt = 0;
    else if (mq.size() > 0 && !bus.out_ready && mcnt < CMAX) mcnt++;
    if (flush) begin
      mq.delete();
      mmain = FVAL;
    end else begin
      if (pop) mmain = mq.pop_front();
      if (acc) mq.push_back(bus.in_data);
      if (mq.size() > 0) mmain = mq[0];
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  int exp_stall[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();

    // Power-on reset
    @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Streaming 1..8 with downstream always ready
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1);
      step("stream");
      check("stream.data_now", bus.out_data, WIDTH'(i));
    end
    drive(1'b0, '0, 1'b1);
    step("stream_drain");

    // Skid absorption then release
    drive(1'b1, 32'hA, 1'b0);
    step("skid_a");
    check("skid_a.in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'hB, 1'b0);
    step("skid_b");
    check("skid_b.in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b0, '0, 1'b0);
    step("skid_hold");
    check("skid_hold.data", bus.out_data, 32'hA);
    drive(1'b0, '0, 1'b1);
    step("skid_pop_a");
    check("skid_pop_a.data", bus.out_data, 32'hB);
    check("skid_pop_a.in_ready", 32'(bus.in_ready), 32'd1);
    step("skid_pop_b");
    check("skid_pop_b.out_valid", 32'(bus.out_valid), 32'd0);

    // Flush while FULL with a new entry offered
    stall_clr = 1'b1;
    drive(1'b1, 32'hA, 1'b0);
    step("fl_a");
    stall_clr = 1'b0;
    drive(1'b1, 32'hB, 1'b0);
    step("fl_b");
    drive(1'b1, 32'hC, 1'b0);
    flush = 1'b1;
    step("flush");
    check("flush.out_data", bus.out_data, FVAL);
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    step("post_flush");
    step("post_flush2");

    // Stall counter saturation and clear
    stall_clr = 1'b1;
    drive(1'b1, 32'h55, 1'b0);
    step("sc_load");
    stall_clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("sc_stall");
      check("sc_stall.const", 32'(stall_cnt), 32'(exp_stall[i]));
    end
    stall_clr = 1'b1;
    step("sc_clr");
    check("sc_clr.const", 32'(stall_cnt), 32'd0);
    stall_clr = 1'b0;
    drive(1'b0, '0, 1'b1);
    step("sc_drain");

    // Asynchronous reset while FULL
    drive(1'b1, 32'h11, 1'b0);
    step("rst_a");
    drive(1'b1, 32'h22, 1'b0);
    step("rst_b");
    drive(1'b0, '0, 1'b0);
    step("rst_stall");
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    reset = 1'b1;
    check_all("rst_release");

    // Randomized back-pressure with occasional flush and counter clear
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 2) != 0));
      flush     = ($urandom_range(0, 63) == 0);
      stall_clr = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    flush     = 1'b0;
    stall_clr = 1'b0;
    drive(1'b0, '0, 1'b1);
    step("final_drain1");
    step("final_drain2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
